set_scan_ctrl: RTL and testbench

- Sequencer for the set-logic unit (LU).
- Captures three circle descriptors (sets A, B, C) and a mode, then walks all 64 points of the 8x8 grid, one point per cycle.
- For each point it forms the 3-bit covered vector and presents it to LU, then counts the points where LU reports a hit.
- Returns the count to the host with a one-cycle valid pulse. Sits between the host interface and the LU instance.

---
 rtl/set_scan_ctrl_pkg.sv | 23 ++
 rtl/lu.sv | 29 ++
 rtl/set_scan_ctrl_circle_cover.sv | 36 +++
 rtl/set_scan_ctrl.sv | 110 +++++++++++
 tb/tb_set_scan_ctrl.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/set_scan_ctrl_pkg.sv
// Shared definitions for the set-scan sequencer: widths, set-operation codes
// and FSM state encodings.
package set_scan_ctrl_pkg;

  localparam int COVERED_SZ = 3;
  localparam int MODE_SZ    = 2;
  localparam int COORD_W    = 4;

  typedef enum logic [MODE_SZ-1:0] {
    MODE1 = 2'd0,  // A
    MODE2 = 2'd1,  // A & B
    MODE3 = 2'd2,  // A ^ B
    MODE4 = 2'd3   // (A | B | C) minus (A & B & C)
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/lu.sv
// Set-logic unit: combines the covered vector {A,B,C} under the selected
// set operation into a single hit bit.
module lu
  import set_scan_ctrl_pkg::*;
(
  input  logic [COVERED_SZ-1:0] covered,
  input  logic [MODE_SZ-1:0]    mode,
  output logic                  hit
);

  logic a;
  logic b;
  logic c;

  always_comb begin
    a   = covered[2];
    b   = covered[1];
    c   = covered[0];
    hit = 1'b0;
    case (mode_e'(mode))
      MODE1:   hit = a;
      MODE2:   hit = a & b;
      MODE3:   hit = a ^ b;
      MODE4:   hit = (a | b | c) & ~(a & b & c);
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/set_scan_ctrl_circle_cover.sv
// Combinational point-in-circle test: covered iff dx^2 + dy^2 <= r^2,
// boundary included.
module circle_cover
  import set_scan_ctrl_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [COORD_W-1:0] r,
  output logic               covered
);

  logic signed [4:0] dx;
  logic signed [4:0] dy;
  logic [3:0]        mag_x;
  logic [3:0]        mag_y;
  logic [7:0]        sq_x;
  logic [7:0]        sq_y;
  logic [7:0]        sq_r;
  logic [8:0]        sum;

  always_comb begin
    dx = $signed({1'b0, x}) - $signed({1'b0, cx});
    dy = $signed({1'b0, y}) - $signed({1'b0, cy});
    // Squaring the magnitude keeps the product unsigned; |d| never exceeds 15.
    mag_x = dx[4] ? (~dx[3:0] + 4'd1) : dx[3:0];
    mag_y = dy[4] ? (~dy[3:0] + 4'd1) : dy[3:0];
    sq_x  = {4'b0, mag_x} * {4'b0, mag_x};
    sq_y  = {4'b0, mag_y} * {4'b0, mag_y};
    sq_r  = {4'b0, r} * {4'b0, r};
    sum   = {1'b0, sq_x} + {1'b0, sq_y};
    covered = (sum <= {1'b0, sq_r});
  end

endmodule

// File: rtl/set_scan_ctrl.sv
// Scan sequencer: captures three circles and a mode, walks the grid one point
// per cycle through a one-stage covered pipeline, and reports the hit count.
module set_scan_ctrl
  import set_scan_ctrl_pkg::*;
#(
  parameter int GRID_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [23:0]        central,
  input  logic [11:0]        radius,
  input  logic [MODE_SZ-1:0] mode,
  output logic               busy,
  output logic               valid,
  output logic [CNT_W-1:0]   candidate
);

  localparam int XY_W  = $clog2(GRID_W);
  localparam int IDX_W = 2 * XY_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(GRID_W * GRID_W - 1);

  state_e                  state_q;
  state_e                  state_d;
  logic [23:0]             central_q;
  logic [11:0]             radius_q;
  logic [MODE_SZ-1:0]      mode_q;
  logic [IDX_W-1:0]        idx_q;
  logic [COVERED_SZ-1:0]   cov_now;
  logic [COVERED_SZ-1:0]   cov_q;
  logic                    occ_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_next;
  logic [CNT_W-1:0]        cand_q;
  logic [COORD_W-1:0]      x;
  logic [COORD_W-1:0]      y;
  logic                    hit;

  assign x = COORD_W'(idx_q[XY_W-1:0]) + COORD_W'(1);
  assign y = COORD_W'(idx_q[IDX_W-1:XY_W]) + COORD_W'(1);

  circle_cover u_cover_a (
    .x(x), .y(y), .cx(central_q[23:20]), .cy(central_q[19:16]),
    .r(radius_q[11:8]), .covered(cov_now[2])
  );
  circle_cover u_cover_b (
    .x(x), .y(y), .cx(central_q[15:12]), .cy(central_q[11:8]),
    .r(radius_q[7:4]), .covered(cov_now[1])
  );
  circle_cover u_cover_c (
    .x(x), .y(y), .cx(central_q[7:4]), .cy(central_q[3:0]),
    .r(radius_q[3:0]), .covered(cov_now[0])
  );

  lu u_lu (
    .covered(cov_q),
    .mode   (mode_q),
    .hit    (hit)
  );

  // Only an occupied pipeline slot may contribute to the count.
  assign cnt_next = cnt_q + CNT_W'(occ_q & hit);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = SCAN;
      SCAN:    if (idx_q == IDX_LAST) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      central_q <= '0;
      radius_q  <= '0;
      mode_q    <= '0;
      idx_q     <= '0;
      cov_q     <= '0;
      occ_q     <= 1'b0;
      cnt_q     <= '0;
      cand_q    <= '0;
    end else begin
      state_q <= state_d;
      cov_q   <= cov_now;
      occ_q   <= (state_q == SCAN);
      if (state_q == IDLE && en) begin
        central_q <= central;
        radius_q  <= radius;
        mode_q    <= mode;
        idx_q     <= '0;
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_next;
        if (state_q == SCAN) idx_q <= idx_q + IDX_W'(1);
      end
      // The DRAIN edge folds in the last point, so cnt_next is the final count.
      if (state_q == DRAIN) cand_q <= cnt_next;
    end
  end

  assign busy      = (state_q == SCAN) || (state_q == DRAIN);
  assign valid     = (state_q == DONE);
  assign candidate = cand_q;

endmodule

// File: tb/tb_set_scan_ctrl.sv
// Self-checking bench for set_scan_ctrl: directed and random scans with
// a counted reference, cycle-exact busy/valid checks, abort and mid-scan cases.
module tb_set_scan_ctrl;
  import set_scan_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] central;
  logic [11:0] radius;
  logic [1:0]  mode;
  logic        busy;
  logic        valid;
  logic [7:0]  candidate;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  set_scan_ctrl #(.GRID_W(8), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .central  (central),
    .radius   (radius),
    .mode     (mode),
    .busy     (busy),
    .valid    (valid),
    .candidate(candidate)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic in_circle(int x, int y, int cx, int cy, int r);
    return ((x - cx) * (x - cx) + (y - cy) * (y - cy)) <= r * r;
  endfunction

  function automatic int model_count(logic [23:0] c, logic [11:0] r, logic [1:0] md);
    int   n = 0;
    logic a, b, cc, h;
    for (int yy = 1; yy <= 8; yy++) begin
      for (int xx = 1; xx <= 8; xx++) begin
        a  = in_circle(xx, yy, int'(c[23:20]), int'(c[19:16]), int'(r[11:8]));
        b  = in_circle(xx, yy, int'(c[15:12]), int'(c[11:8]),  int'(r[7:4]));
        cc = in_circle(xx, yy, int'(c[7:4]),   int'(c[3:0]),   int'(r[3:0]));
        case (md)
          2'd0:    h = a;
          2'd1:    h = a && b;
          2'd2:    h = a != b;
          default: h = (a || b || cc) && !(a && b && cc);
        endcase
        if (h) n++;
      end
    end
    return n;
  endfunction

  // Scoreboard: each valid pulse pops one expected candidate.
  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
      else check("candidate", int'(candidate), int'(exp_q.pop_front()));
    end
  end

  // Entered right after a posedge (+#1). exp < 0 means use the reference model.
  task automatic run_scan(input logic [23:0] c, input logic [11:0] r,
                          input logic [1:0] md, input int exp,
                          input int pulse_at, input int reset_at);
    bit aborted;
    central = c;
    radius  = r;
    mode    = md;
    en      = 1'b1;
    if (reset_at == 0) exp_q.push_back(8'((exp < 0) ? model_count(c, r, md) : exp));
    @(posedge clk);  // edge k
    #1;
    en = 1'b0;
    for (int m = 1; m <= 68; m++) begin
      if (m == pulse_at) begin
        en      = 1'b1;
        central = $urandom;
        radius  = 12'($urandom);
        mode    = 2'($urandom_range(0, 3));
      end
      if (pulse_at > 0 && m == pulse_at + 1) en = 1'b0;
      if (reset_at > 0 && m == reset_at) rst = 1'b1;
      if (reset_at > 0 && m == reset_at + 1) rst = 1'b0;
      @(negedge clk);
      aborted = (reset_at > 0) && (m > reset_at);
      check("busy", int'(busy), int'(!aborted && m <= 65));
      check("valid", int'(valid), int'(!aborted && m == 66));
      if (reset_at > 0 && m == reset_at + 1) check("cand_after_rst", int'(candidate), 0);
      @(posedge clk);
      #1;
    end
    check("queue_empty", exp_q.size(), 0);
    en = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    central = '0;
    radius  = '0;
    mode    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_candidate", int'(candidate), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_scan(24'h44FFFF, 12'h000, 2'd0, 1,  0, 0);   // single centre point
    run_scan(24'h44FFFF, 12'hF00, 2'd0, 64, 0, 0);   // whole grid
    run_scan(24'h11FFFF, 12'h100, 2'd0, 3,  0, 0);   // corner, edge inclusion
    run_scan(24'h1188FF, 12'h110, 2'd1, 0,  0, 0);
    run_scan(24'h4444FF, 12'h220, 2'd2, 0,  0, 0);
    run_scan(24'h44FFFF, 12'h200, 2'd2, 13, 0, 0);
    run_scan(24'h444444, 12'h111, 2'd3, 0,  0, 0);
    run_scan(24'h44FFFF, 12'h200, 2'd3, 13, 0, 0);
    run_scan(24'h44FFFF, 12'h200, 2'd0, 13, 20, 0);  // en + input change mid-scan
    run_scan(24'h44FFFF, 12'hF00, 2'd0, 64, 0, 30);  // aborted by reset
    run_scan(24'h44FFFF, 12'hF00, 2'd0, 64, 0, 0);   // fresh scan after abort
    for (int i = 0; i < 5; i++)
      run_scan(24'($urandom), 12'($urandom), 2'($urandom_range(0, 3)), -1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
